// File: rtl/pe_oob_pkg.sv
// ---------------------------------------------------------------------------
// pe_oob_pkg
// Shared definitions for the PE OOB command decoder:
//   - OOB word type encoding carried on sys__pe__oob_type
//   - decoder FSM state encoding
//   - SOD header field positions and widths
//   - decoded configuration record handed to the stOp control driver
// No ports (package).
// ---------------------------------------------------------------------------
package pe_oob_pkg;

    typedef enum logic [1:0] {
        OOB_SOD  = 2'b00,
        OOB_MOD  = 2'b01,
        OOB_EOD  = 2'b10,
        OOB_RSVD = 2'b11
    } pe_oob_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HDR   = 2'b01,
        ST_MASK  = 2'b10,
        ST_ISSUE = 2'b11
    } pe_oob_state_e;

    // SOD header layout: opcode[31:24], tag[23:16], num_oprnds[15:0]
    localparam int OPCODE_W           = 8;
    localparam int TAG_W              = 8;
    localparam int NUM_OPRNDS_W       = 16;
    localparam int SOD_OPCODE_LSB     = 24;
    localparam int SOD_TAG_LSB        = 16;
    localparam int SOD_NUM_OPRNDS_LSB = 0;

    // Storage width of the variable-size fields in the config record; the
    // decoder uses the low NUM_LANES / OOB_DATA_W bits and zeroes the rest.
    localparam int CFG_LANES_MAX  = 64;
    localparam int CFG_DATA_W_MAX = 64;

    typedef struct packed {
        logic [OPCODE_W-1:0]       opcode;
        logic [TAG_W-1:0]          tag;
        logic [NUM_OPRNDS_W-1:0]   num_oprnds;
        logic [CFG_LANES_MAX-1:0]  lane_en;
        logic [CFG_DATA_W_MAX-1:0] stop_op;
    } pe_oob_cfg_t;

endpackage

// File: rtl/pe_oob_cmd_decode_if.sv
// ---------------------------------------------------------------------------
// pe_oob_cmd_decode_if
// Bundles every non-clock/reset signal of the OOB command decoder.
//   OOB stream  : sys__pe__oob_valid/type/data in, pe__sys__oob_ready out
//   Config out  : oob__cntl__cfg_* out, cntl__oob__cfg_ready in
//   Completion  : cntl__oob__complete in (one pulse per finished stOp op)
//   Status      : oob__sys__outstanding, oob__sys__proto_err, oob__sys__err_cnt
// Modports: slave  = the decoder's view
//           master = the surrounding system (sys + stOp control) view
// ---------------------------------------------------------------------------
interface pe_oob_cmd_decode_if
    import pe_oob_pkg::*;
#(
    parameter int NUM_LANES       = 32,
    parameter int OOB_DATA_W      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ERR_CNT_W       = 8
) ();
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                    sys__pe__oob_valid;
    logic                    pe__sys__oob_ready;
    logic [1:0]              sys__pe__oob_type;
    logic [OOB_DATA_W-1:0]   sys__pe__oob_data;

    logic                    oob__cntl__cfg_valid;
    logic                    cntl__oob__cfg_ready;
    logic [OPCODE_W-1:0]     oob__cntl__cfg_opcode;
    logic [TAG_W-1:0]        oob__cntl__cfg_tag;
    logic [NUM_OPRNDS_W-1:0] oob__cntl__cfg_num_oprnds;
    logic [NUM_LANES-1:0]    oob__cntl__cfg_lane_en;
    logic [OOB_DATA_W-1:0]   oob__cntl__cfg_stop_op;

    logic                    cntl__oob__complete;
    logic [CNT_W-1:0]        oob__sys__outstanding;
    logic                    oob__sys__proto_err;
    logic [ERR_CNT_W-1:0]    oob__sys__err_cnt;

    modport slave (
        input  sys__pe__oob_valid, sys__pe__oob_type, sys__pe__oob_data,
        output pe__sys__oob_ready,
        output oob__cntl__cfg_valid, oob__cntl__cfg_opcode, oob__cntl__cfg_tag,
        output oob__cntl__cfg_num_oprnds, oob__cntl__cfg_lane_en, oob__cntl__cfg_stop_op,
        input  cntl__oob__cfg_ready, cntl__oob__complete,
        output oob__sys__outstanding, oob__sys__proto_err, oob__sys__err_cnt
    );

    modport master (
        output sys__pe__oob_valid, sys__pe__oob_type, sys__pe__oob_data,
        input  pe__sys__oob_ready,
        input  oob__cntl__cfg_valid, oob__cntl__cfg_opcode, oob__cntl__cfg_tag,
        input  oob__cntl__cfg_num_oprnds, oob__cntl__cfg_lane_en, oob__cntl__cfg_stop_op,
        output cntl__oob__cfg_ready, cntl__oob__complete,
        input  oob__sys__outstanding, oob__sys__proto_err, oob__sys__err_cnt
    );

endinterface

// File: rtl/pe_oob_outstanding_cntr.sv
// ---------------------------------------------------------------------------
// pe_oob_outstanding_cntr
// Tracks stOp commands issued but not yet completed.
//   clk, rst      : clock, asynchronous active-high reset
//   i_inc         : a config was transferred to the stOp driver
//   i_dec         : a stOp-complete pulse arrived
//   o_count       : current outstanding count
//   o_at_limit    : count has reached MAX_OUTSTANDING (no more issues allowed)
//   o_underflow   : combinational pulse, completion seen with nothing outstanding
// ---------------------------------------------------------------------------
module pe_oob_outstanding_cntr #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_limit,
    output logic             o_underflow
);
    logic [CNT_W-1:0] r_count;
    logic             w_zero;

    assign w_zero      = (r_count == '0);
    assign o_at_limit  = (r_count >= CNT_W'(MAX_OUTSTANDING));
    // An issue and a completion in the same cycle cancel out, so only a lone
    // completion against an empty count is an underflow.
    assign o_underflow = i_dec & ~i_inc & w_zero;
    assign o_count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (!o_at_limit) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_dec && !i_inc && !w_zero) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pe_oob_cmd_decode.sv
// ---------------------------------------------------------------------------
// pe_oob_cmd_decode
// Assembles SOD/MOD/EOD OOB word triplets into one stOp configuration and
// offers it to the regFile->stOpCntl driver with valid/ready. New packets are
// throttled while MAX_OUTSTANDING ops are in flight; malformed sequences and
// stray completions are counted as protocol errors.
//   clk            : single rising-edge clock
//   reset_poweron  : asynchronous active-high reset
//   oob_if (slave) : OOB stream, decoded config, completion and status
// ---------------------------------------------------------------------------
module pe_oob_cmd_decode
    import pe_oob_pkg::*;
#(
    parameter int NUM_LANES       = 32,
    parameter int OOB_DATA_W      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    pe_oob_cmd_decode_if.slave   oob_if
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    pe_oob_state_e         r_state;
    logic                  r_live;
    logic [OOB_DATA_W-1:0] r_hdr;
    logic [NUM_LANES-1:0]  r_mask;
    pe_oob_cfg_t           r_cfg;
    logic                  r_cfg_valid;
    logic                  r_proto_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    pe_oob_type_e          w_type;
    logic                  w_ready;
    logic                  w_word_xfer;
    logic                  w_cfg_xfer;
    logic                  w_word_err;
    logic                  w_at_limit;
    logic                  w_underflow;
    logic [1:0]            w_err_inc;
    logic [CNT_W-1:0]      w_count;

    function automatic pe_oob_cfg_t build_cfg(input logic [OOB_DATA_W-1:0] hdr,
                                              input logic [NUM_LANES-1:0]  mask,
                                              input logic [OOB_DATA_W-1:0] eod);
        pe_oob_cfg_t cfg;
        cfg                        = '0;
        cfg.opcode                 = hdr[SOD_OPCODE_LSB +: OPCODE_W];
        cfg.tag                    = hdr[SOD_TAG_LSB +: TAG_W];
        cfg.num_oprnds             = hdr[SOD_NUM_OPRNDS_LSB +: NUM_OPRNDS_W];
        cfg.lane_en[NUM_LANES-1:0] = mask;
        cfg.stop_op[OOB_DATA_W-1:0] = eod;
        return cfg;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] err_sat_add(input logic [ERR_CNT_W-1:0] a,
                                                         input logic [1:0]           n);
        logic [ERR_CNT_W+1:0] s;
        s = {2'b00, a} + {{ERR_CNT_W{1'b0}}, n};
        if (s > {2'b00, {ERR_CNT_W{1'b1}}}) begin
            return '1;
        end
        return s[ERR_CNT_W-1:0];
    endfunction

    assign w_type      = pe_oob_type_e'(oob_if.sys__pe__oob_type);
    assign w_word_xfer = oob_if.sys__pe__oob_valid & w_ready;
    assign w_cfg_xfer  = r_cfg_valid & oob_if.cntl__oob__cfg_ready;

    // r_live keeps ready low while reset is held and until the first clock
    // edge after release.
    always_comb begin
        w_ready = 1'b0;
        if (r_live) begin
            case (r_state)
                ST_IDLE:         w_ready = ~w_at_limit;
                ST_HDR, ST_MASK: w_ready = 1'b1;
                default:         w_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_word_err = 1'b0;
        if (w_word_xfer) begin
            case (r_state)
                ST_IDLE: w_word_err = (w_type != OOB_SOD);
                ST_HDR:  w_word_err = (w_type != OOB_MOD);
                ST_MASK: w_word_err = (w_type != OOB_EOD);
                default: w_word_err = 1'b0;
            endcase
        end
    end

    assign w_err_inc = {1'b0, w_word_err} + {1'b0, w_underflow};

    pe_oob_outstanding_cntr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk         (clk),
        .rst         (reset_poweron),
        .i_inc       (w_cfg_xfer),
        .i_dec       (oob_if.cntl__oob__complete),
        .o_count     (w_count),
        .o_at_limit  (w_at_limit),
        .o_underflow (w_underflow)
    );

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_hdr       <= '0;
            r_mask      <= '0;
            r_cfg       <= '0;
            r_cfg_valid <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_word_xfer && w_type == OOB_SOD) begin
                        r_hdr   <= oob_if.sys__pe__oob_data;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_word_xfer) begin
                        case (w_type)
                            OOB_MOD: begin
                                r_mask  <= oob_if.sys__pe__oob_data[NUM_LANES-1:0];
                                r_state <= ST_MASK;
                            end
                            // A fresh SOD restarts the packet with the new header.
                            OOB_SOD: r_hdr   <= oob_if.sys__pe__oob_data;
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_MASK: begin
                    if (w_word_xfer) begin
                        case (w_type)
                            OOB_EOD: begin
                                r_cfg       <= build_cfg(r_hdr, r_mask, oob_if.sys__pe__oob_data);
                                r_cfg_valid <= 1'b1;
                                r_state     <= ST_ISSUE;
                            end
                            OOB_SOD: begin
                                r_hdr   <= oob_if.sys__pe__oob_data;
                                r_state <= ST_HDR;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (oob_if.cntl__oob__cfg_ready) begin
                        r_cfg_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_proto_err <= 1'b0;
            r_err_cnt   <= '0;
        end else if (w_err_inc != 2'd0) begin
            r_proto_err <= 1'b1;
            r_err_cnt   <= err_sat_add(r_err_cnt, w_err_inc);
        end
    end

    assign oob_if.pe__sys__oob_ready        = w_ready;
    assign oob_if.oob__cntl__cfg_valid      = r_cfg_valid;
    assign oob_if.oob__cntl__cfg_opcode     = r_cfg.opcode;
    assign oob_if.oob__cntl__cfg_tag        = r_cfg.tag;
    assign oob_if.oob__cntl__cfg_num_oprnds = r_cfg.num_oprnds;
    assign oob_if.oob__cntl__cfg_lane_en    = r_cfg.lane_en[NUM_LANES-1:0];
    assign oob_if.oob__cntl__cfg_stop_op    = r_cfg.stop_op[OOB_DATA_W-1:0];
    assign oob_if.oob__sys__outstanding     = w_count;
    assign oob_if.oob__sys__proto_err       = r_proto_err;
    assign oob_if.oob__sys__err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_pe_oob_cmd_decode.sv
// ---------------------------------------------------------------------------
// tb_pe_oob_cmd_decode
// Directed bench: packets are pushed as expected configs into a queue when
// sent; a monitor pops and compares on every config transfer. Status outputs
// are compared directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pe_oob_cmd_decode;

    localparam logic [1:0] T_SOD  = 2'b00;
    localparam logic [1:0] T_MOD  = 2'b01;
    localparam logic [1:0] T_EOD  = 2'b10;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  tag;
        logic [15:0] num;
        logic [31:0] lane;
        logic [31:0] stop;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];

    pe_oob_cmd_decode_if #(
        .NUM_LANES(32), .OOB_DATA_W(32), .MAX_OUTSTANDING(4), .ERR_CNT_W(8)
    ) bus ();

    pe_oob_cmd_decode #(
        .NUM_LANES(32), .OOB_DATA_W(32), .MAX_OUTSTANDING(4), .ERR_CNT_W(8)
    ) dut (
        .clk           (clk),
        .reset_poweron (rst),
        .oob_if        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [1:0] t, input logic [31:0] d);
        bit done;
        done = 1'b0;
        bus.sys__pe__oob_valid = 1'b1;
        bus.sys__pe__oob_type  = t;
        bus.sys__pe__oob_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.pe__sys__oob_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.sys__pe__oob_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL word_accept_timeout actual=not_accepted required=accepted type=%0d", t);
        end
    endtask

    task automatic send_pkt(input logic [31:0] sod, input logic [31:0] mod, input logic [31:0] eod);
        exp_t e;
        e.op   = sod[31:24];
        e.tag  = sod[23:16];
        e.num  = sod[15:0];
        e.lane = mod;
        e.stop = eod;
        exp_q.push_back(e);
        send_word(T_SOD, sod);
        send_word(T_MOD, mod);
        send_word(T_EOD, eod);
    endtask

    task automatic pulse_complete();
        bus.cntl__oob__complete = 1'b1;
        tick();
        bus.cntl__oob__complete = 1'b0;
    endtask

    // Scoreboard monitor: a transfer happens on the rising edge following a
    // falling edge where valid and ready are both high.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (!rst && bus.oob__cntl__cfg_valid && bus.cntl__oob__cfg_ready) begin
                a = {bus.oob__cntl__cfg_opcode, bus.oob__cntl__cfg_tag,
                     bus.oob__cntl__cfg_num_oprnds, bus.oob__cntl__cfg_lane_en,
                     bus.oob__cntl__cfg_stop_op};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL cfg_unexpected actual=%0h required=no_transfer", a);
                end else begin
                    e = exp_q.pop_front();
                    chk("cfg_fields", 128'(a), 128'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.sys__pe__oob_valid   = 1'b0;
        bus.sys__pe__oob_type    = 2'b00;
        bus.sys__pe__oob_data    = '0;
        bus.cntl__oob__cfg_ready = 1'b0;
        bus.cntl__oob__complete  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready",       128'(bus.pe__sys__oob_ready), 128'(0));
        chk("rst_cfg_valid",   128'(bus.oob__cntl__cfg_valid), 128'(0));
        chk("rst_outstanding", 128'(bus.oob__sys__outstanding), 128'(0));
        chk("rst_err",         128'({bus.oob__sys__proto_err, bus.oob__sys__err_cnt}), 128'(0));
        chk("rst_cfg_data",    128'({bus.oob__cntl__cfg_opcode, bus.oob__cntl__cfg_lane_en,
                                     bus.oob__cntl__cfg_stop_op}), 128'(0));
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 128'(bus.pe__sys__oob_ready), 128'(1));

        // 1: basic packet, cfg_valid the cycle after EOD acceptance
        bus.cntl__oob__cfg_ready = 1'b1;
        send_pkt(32'h1203_0010, 32'hFFFF_FFFF, 32'h0000_0005);
        chk("t1_cfg_valid_latency", 128'(bus.oob__cntl__cfg_valid), 128'(1));
        tick();
        chk("t1_cfg_valid_drop", 128'(bus.oob__cntl__cfg_valid), 128'(0));
        chk("t1_outstanding",    128'(bus.oob__sys__outstanding), 128'(1));
        chk("t1_hold_fields",    128'({bus.oob__cntl__cfg_opcode, bus.oob__cntl__cfg_stop_op}),
                                 128'({8'h12, 32'h5}));
        pulse_complete();
        chk("t1_outstanding_done", 128'(bus.oob__sys__outstanding), 128'(0));

        // 2: backpressure on cfg_ready for 10 cycles
        bus.cntl__oob__cfg_ready = 1'b0;
        send_pkt(32'h1203_0010, 32'hFFFF_FFFF, 32'h0000_0005);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_stall_stable",
                128'({bus.oob__cntl__cfg_valid, bus.pe__sys__oob_ready, bus.oob__cntl__cfg_opcode,
                      bus.oob__cntl__cfg_tag, bus.oob__cntl__cfg_num_oprnds,
                      bus.oob__cntl__cfg_lane_en, bus.oob__cntl__cfg_stop_op}),
                128'({1'b1, 1'b0, 8'h12, 8'h03, 16'h0010, 32'hFFFF_FFFF, 32'h5}));
        end
        tick();
        bus.cntl__oob__cfg_ready = 1'b1;
        tick();
        chk("t2_released", 128'({bus.oob__cntl__cfg_valid, bus.oob__sys__outstanding}),
                           128'({1'b0, 3'd1}));
        pulse_complete();

        // 3: fill to MAX_OUTSTANDING, ready held low in IDLE until a completion
        send_pkt(32'h2040_0100, 32'h0000_0001, 32'hA000_0000);
        send_pkt(32'h2141_0101, 32'h0000_0002, 32'hA000_0001);
        send_pkt(32'h2242_0102, 32'h0000_0004, 32'hA000_0002);
        send_pkt(32'h2343_0103, 32'h0000_0008, 32'hA000_0003);
        tick();
        tick();
        chk("t3_outstanding_max", 128'(bus.oob__sys__outstanding), 128'(4));
        chk("t3_ready_blocked",   128'(bus.pe__sys__oob_ready), 128'(0));
        pulse_complete();
        chk("t3_ready_reopened",  128'(bus.pe__sys__oob_ready), 128'(1));
        chk("t3_outstanding_3",   128'(bus.oob__sys__outstanding), 128'(3));

        // 4: coincident complete + cfg transfer, then underflow
        pulse_complete();
        chk("t4_outstanding_2", 128'(bus.oob__sys__outstanding), 128'(2));
        bus.cntl__oob__cfg_ready = 1'b0;
        send_pkt(32'h5566_0007, 32'h0F0F_0F0F, 32'h0000_0077);
        bus.cntl__oob__cfg_ready = 1'b1;
        bus.cntl__oob__complete  = 1'b1;
        tick();
        bus.cntl__oob__complete  = 1'b0;
        chk("t4_coincident_hold", 128'(bus.oob__sys__outstanding), 128'(2));
        pulse_complete();
        pulse_complete();
        chk("t4_drained_no_err", 128'({bus.oob__sys__outstanding, bus.oob__sys__err_cnt}), 128'(0));
        pulse_complete();
        chk("t4_underflow_err", 128'({bus.oob__sys__proto_err, bus.oob__sys__err_cnt}),
                                128'({1'b1, 8'd1}));
        chk("t4_underflow_cnt", 128'(bus.oob__sys__outstanding), 128'(0));

        // 5: SOD restart uses second header; stray MOD in IDLE dropped
        begin
            exp_t e;
            e = {8'h7F, 8'hA5, 16'hBEEF, 32'h0000_00F0, 32'hCAFE_0001};
            exp_q.push_back(e);
        end
        send_word(T_SOD, 32'h0102_0003);
        send_word(T_SOD, 32'h7FA5_BEEF);
        send_word(T_MOD, 32'h0000_00F0);
        send_word(T_EOD, 32'hCAFE_0001);
        tick();
        chk("t5_restart_err", 128'(bus.oob__sys__err_cnt), 128'(2));
        send_word(T_MOD, 32'h1234_5678);
        tick();
        chk("t5_idle_mod_err", 128'(bus.oob__sys__err_cnt), 128'(3));
        chk("t5_outstanding",  128'(bus.oob__sys__outstanding), 128'(1));

        // 6: asynchronous reset between MOD and EOD
        send_word(T_SOD, 32'h3344_0002);
        send_word(T_MOD, 32'h5555_0000);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_ctl", 128'({bus.pe__sys__oob_ready, bus.oob__cntl__cfg_valid,
                                  bus.oob__sys__outstanding, bus.oob__sys__proto_err,
                                  bus.oob__sys__err_cnt}), 128'(0));
        chk("t6_async_data", 128'({bus.oob__cntl__cfg_opcode, bus.oob__cntl__cfg_tag,
                                   bus.oob__cntl__cfg_lane_en, bus.oob__cntl__cfg_stop_op}), 128'(0));
        tick();
        rst = 1'b0;
        send_word(T_EOD, 32'h0000_0099);
        repeat (3) tick();
        chk("t6_eod_dropped", 128'({bus.oob__cntl__cfg_valid, bus.oob__sys__proto_err,
                                    bus.oob__sys__err_cnt}), 128'({1'b0, 1'b1, 8'd1}));

        // Error counter saturation
        for (int i = 0; i < 260; i++) send_word(T_MOD, 32'(i));
        tick();
        chk("err_cnt_saturate", 128'(bus.oob__sys__err_cnt), 128'(255));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
